// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the 5-stage pipeline control path.
//   REGADDR_W     : register-file index width
//   pctrl_state_t : hazard-controller FSM states (RUN, DWAIT, DRAIN, HALTED)
//   pipe_ctrl_t   : PC enable plus write-enable / flush vectors for the four
//                   pipeline registers, indexed by IFID/IDEX/EXMEM/MEMWB
//   resolve_run() : control word for the redirect / load-use / imiss / advance
//                   cases, shared by the RUN state and the DWAIT exit cycle
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  localparam int REGADDR_W = 5;

  // Bit positions inside the per-register enable / flush vectors.
  localparam int IFID  = 0;
  localparam int IDEX  = 1;
  localparam int EXMEM = 2;
  localparam int MEMWB = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } pctrl_state_t;

  typedef struct packed {
    logic       pc_en;
    logic [3:0] w;    // register write enable
    logic [3:0] rst;  // bubble insert, only meaningful where w=1
  } pipe_ctrl_t;

  // Lower-priority cases once halt and data-memory wait are out of the way.
  function automatic pipe_ctrl_t resolve_run(input logic       redirect,
                                             input logic       lu_stall,
                                             input logic       ihit,
                                             input logic [3:0] flush_mask);
    pipe_ctrl_t c;
    c.pc_en = 1'b1;
    c.w     = 4'b1111;
    c.rst   = 4'b0000;
    if (redirect) begin
      // PC takes the target even without a valid fetch; younger stages die.
      c.rst = flush_mask;
    end else if (lu_stall) begin
      // Hold the consumer in IF/ID, bubble into ID/EX. Also covers a
      // simultaneous imiss: IF/ID simply holds, no bubble there.
      c.pc_en     = 1'b0;
      c.w[IFID]   = 1'b0;
      c.rst[IDEX] = 1'b1;
    end else if (!ihit) begin
      c.pc_en     = 1'b0;
      c.rst[IFID] = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use compare between the load in ID/EX and the sources of
// the instruction in IF/ID. Register 0 is hard-wired and never stalls.
// Ports:
//   exDRE      in  ID/EX holds a load
//   exrt       in  load destination register
//   idrs, idrt in  source registers of the IF/ID instruction
//   lu_stall   out load-use hazard present
// -----------------------------------------------------------------------------
module hazard_detect #(
  parameter int REGADDR_W = cpu_types_pkg::REGADDR_W
) (
  input  logic                 exDRE,
  input  logic [REGADDR_W-1:0] exrt,
  input  logic [REGADDR_W-1:0] idrs,
  input  logic [REGADDR_W-1:0] idrt,
  output logic                 lu_stall
);

  assign lu_stall = exDRE && (exrt != '0) && ((exrt == idrs) || (exrt == idrt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central sequencer for the 5-stage pipeline: drives PC enable and the
// write-enable / flush pair of IF/ID, ID/EX, EX/MEM and MEM/WB. Priority:
// halt drain, data-memory wait, redirect, load-use, instruction-memory wait.
// The FSM state is the only registered control state; outputs are
// combinational from state and inputs.
// Ports:
//   CLK, nRST             clock, synchronous active-low reset
//   ihit, dhit            instruction / data memory ready this cycle
//   memDRE, memDWE        EX/MEM holds a load / store
//   exDRE, exrt           ID/EX load and its destination
//   idrs, idrt            IF/ID source registers
//   redirect              taken branch / jump resolved in EX/MEM
//   memHALT               EX/MEM holds HALT
//   pcEN                  PC loads next PC
//   xxW, xxRST            per-register enable / bubble insert
//   halted                processor stopped, sticky until reset
// Build option PIPE_PERF_CNT_EN adds 32-bit stall_cnt, flush_cnt, dwait_cnt.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REGADDR_W   = cpu_types_pkg::REGADDR_W,
  parameter int FLUSH_DEPTH = 3
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 ihit,
  input  logic                 dhit,
  input  logic                 memDRE,
  input  logic                 memDWE,
  input  logic                 exDRE,
  input  logic [REGADDR_W-1:0] exrt,
  input  logic [REGADDR_W-1:0] idrs,
  input  logic [REGADDR_W-1:0] idrt,
  input  logic                 redirect,
  input  logic                 memHALT,
  output logic                 pcEN,
  output logic                 ifidW,
  output logic                 ifidRST,
  output logic                 idexW,
  output logic                 idexRST,
  output logic                 exmemW,
  output logic                 exmemRST,
  output logic                 memwbW,
  output logic                 memwbRST,
  output logic                 halted
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt,
  output logic [31:0]          dwait_cnt
`endif
);

  import cpu_types_pkg::*;

  // Younger registers cleared on a redirect, counted from IF/ID upward.
  localparam logic [3:0] FLUSH_MASK = 4'((1 << FLUSH_DEPTH) - 1);

  pctrl_state_t state, state_next;
  pipe_ctrl_t   ctrl;
  logic         lu_stall;
  logic         dmem_stall;
  logic         resolve_en;

  hazard_detect #(.REGADDR_W(REGADDR_W)) u_hazard_detect (
    .exDRE    (exDRE),
    .exrt     (exrt),
    .idrs     (idrs),
    .idrt     (idrt),
    .lu_stall (lu_stall)
  );

  // A memory access completing this cycle (dhit=1) is not a stall.
  assign dmem_stall = (memDRE || memDWE) && !dhit;

  // Cycles in which redirect / load-use / imiss / advance are decided.
  assign resolve_en = ((state == RUN) && !memHALT && !dmem_stall) ||
                      ((state == DWAIT) && dhit);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (!nRST) state <= RUN;
    else       state <= state_next;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path
  // through the case can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      RUN: begin
        if (memHALT)         state_next = DRAIN;
        else if (dmem_stall) state_next = DWAIT;
      end
      DWAIT:   if (dhit) state_next = RUN;
      DRAIN:   state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  // Output logic. Everything is forced idle while reset is held, independent
  // of the state register, so the pipeline cannot move during reset.
  always_comb begin
    ctrl = '0;
    if (nRST) begin
      unique case (state)
        RUN: begin
          if (memHALT) begin
            // Push HALT into MEM/WB; front end freezes behind it.
            ctrl.w[EXMEM] = 1'b1;
            ctrl.w[MEMWB] = 1'b1;
          end else if (resolve_en) begin
            ctrl = resolve_run(redirect, lu_stall, ihit, FLUSH_MASK);
          end
        end
        DWAIT: begin
          // EX/MEM stays frozen, so a redirect seen here is still valid
          // when dhit arrives.
          if (resolve_en) ctrl = resolve_run(redirect, lu_stall, ihit, FLUSH_MASK);
        end
        DRAIN:   ctrl.w[MEMWB] = 1'b1;
        default: ctrl = '0;
      endcase
    end
  end

  assign pcEN     = ctrl.pc_en;
  assign ifidW    = ctrl.w[IFID];
  assign ifidRST  = ctrl.rst[IFID];
  assign idexW    = ctrl.w[IDEX];
  assign idexRST  = ctrl.rst[IDEX];
  assign exmemW   = ctrl.w[EXMEM];
  assign exmemRST = ctrl.rst[EXMEM];
  assign memwbW   = ctrl.w[MEMWB];
  assign memwbRST = ctrl.rst[MEMWB];
  assign halted   = nRST && (state == HALTED);

`ifdef PIPE_PERF_CNT_EN
  logic stall_evt;
  logic flush_evt;

  assign stall_evt = resolve_en && !redirect && lu_stall;
  assign flush_evt = resolve_en && redirect;

  // Counters wrap naturally; none of the events can occur in HALTED, the
  // explicit guard keeps them frozen there regardless.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      dwait_cnt <= '0;
    end else if (state != HALTED) begin
      if (stall_evt)      stall_cnt <= stall_cnt + 32'd1;
      if (flush_evt)      flush_cnt <= flush_cnt + 32'd1;
      if (state == DWAIT) dwait_cnt <= dwait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl. Each step drives one cycle of inputs
// and pushes the hand-derived control word onto a scoreboard queue; the word
// is popped and compared against the DUT at the falling edge of that cycle.
// Control word order:
//   {halted, pcEN, memwbW, exmemW, idexW, ifidW,
//    memwbRST, exmemRST, idexRST, ifidRST}
// With PIPE_PERF_CNT_EN defined the performance counters are also checked.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam logic [9:0] C_ZERO   = 10'b0_0_0000_0000;
  localparam logic [9:0] C_ADV    = 10'b0_1_1111_0000;
  localparam logic [9:0] C_LU     = 10'b0_0_1110_0010;
  localparam logic [9:0] C_IMISS  = 10'b0_0_1111_0001;
  localparam logic [9:0] C_REDIR  = 10'b0_1_1111_0111;
  localparam logic [9:0] C_HALTC  = 10'b0_0_1100_0000;
  localparam logic [9:0] C_DRAIN  = 10'b0_0_1000_0000;
  localparam logic [9:0] C_HALTED = 10'b1_0_0000_0000;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, memDRE, memDWE, exDRE, redirect, memHALT;
  logic [4:0] exrt, idrs, idrt;
  logic       pcEN, ifidW, ifidRST, idexW, idexRST;
  logic       exmemW, exmemRST, memwbW, memwbRST, halted;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, dwait_cnt;
`endif

  logic [9:0] obs;
  assign obs = {halted, pcEN, memwbW, exmemW, idexW, ifidW,
                memwbRST, exmemRST, idexRST, ifidRST};

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .ihit     (ihit),
    .dhit     (dhit),
    .memDRE   (memDRE),
    .memDWE   (memDWE),
    .exDRE    (exDRE),
    .exrt     (exrt),
    .idrs     (idrs),
    .idrt     (idrt),
    .redirect (redirect),
    .memHALT  (memHALT),
    .pcEN     (pcEN),
    .ifidW    (ifidW),
    .ifidRST  (ifidRST),
    .idexW    (idexW),
    .idexRST  (idexRST),
    .exmemW   (exmemW),
    .exmemRST (exmemRST),
    .memwbW   (memwbW),
    .memwbRST (memwbRST),
    .halted   (halted)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .dwait_cnt (dwait_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    nRST     = 1'b1;
    ihit     = 1'b1;
    dhit     = 1'b0;
    memDRE   = 1'b0;
    memDWE   = 1'b0;
    exDRE    = 1'b0;
    exrt     = 5'd0;
    idrs     = 5'd0;
    idrt     = 5'd0;
    redirect = 1'b0;
    memHALT  = 1'b0;
  endtask

  // One clock cycle: inputs already driven by the caller.
  task automatic step(input string tag, input logic [9:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    @(negedge CLK);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, {22'd0, obs}, {22'd0, e.exp});
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    set_idle();
    nRST = 1'b0;

    // Reset: outputs idle even with activity on the inputs.
    step("reset_0", C_ZERO);
    memHALT = 1'b1; redirect = 1'b1;
    step("reset_1", C_ZERO);

    set_idle();
`ifdef PIPE_PERF_CNT_EN
    @(negedge CLK);
    check("cnt_reset_stall", stall_cnt, 32'd0);
    check("cnt_reset_flush", flush_cnt, 32'd0);
    check("cnt_reset_dwait", dwait_cnt, 32'd0);
    @(posedge CLK); #1;
`endif
    step("first_advance", C_ADV);

    // Load-use via rs: exactly one stall cycle.
    exDRE = 1'b1; exrt = 5'd8; idrs = 5'd8;
    step("lu_rs", C_LU);
    set_idle();
    step("lu_rs_release", C_ADV);

    // Register 0 never stalls.
    exDRE = 1'b1; exrt = 5'd0; idrs = 5'd0; idrt = 5'd0;
    step("lu_r0", C_ADV);

    // Load-use via rt.
    set_idle();
    exDRE = 1'b1; exrt = 5'd9; idrs = 5'd3; idrt = 5'd9;
    step("lu_rt", C_LU);

    // Load-use and imiss together: load-use wins, no IF/ID bubble.
    set_idle();
    exDRE = 1'b1; exrt = 5'd8; idrs = 5'd8; ihit = 1'b0;
    step("lu_and_imiss", C_LU);

    // Imiss alone.
    set_idle();
    ihit = 1'b0;
    step("imiss", C_IMISS);

    // Matching registers without a load.
    set_idle();
    exrt = 5'd8; idrs = 5'd8;
    step("no_load_match", C_ADV);

    // Data-memory wait: three waiting cycles, then full advance.
    set_idle();
    memDRE = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("dwait_%0d", i), C_ZERO);
    dhit = 1'b1;
    step("dwait_done", C_ADV);

    // Store completing immediately: no wait state.
    set_idle();
    memDWE = 1'b1; dhit = 1'b1;
    step("store_hit", C_ADV);
    set_idle();
    step("store_hit_after", C_ADV);

    // Redirect without a valid fetch.
    ihit = 1'b0; redirect = 1'b1;
    step("redirect_imiss", C_REDIR);

    // Redirect beats load-use.
    set_idle();
    redirect = 1'b1; exDRE = 1'b1; exrt = 5'd4; idrt = 5'd4;
    step("redirect_over_lu", C_REDIR);

    // Redirect held through a data wait, acted on in the dhit cycle.
    set_idle();
    memDRE = 1'b1; redirect = 1'b1;
    step("dwait_redir_0", C_ZERO);
    step("dwait_redir_1", C_ZERO);
    dhit = 1'b1;
    step("dwait_redir_hit", C_REDIR);

    // Load-use resolved in the DWAIT exit cycle.
    set_idle();
    memDRE = 1'b1;
    step("dwait_lu_0", C_ZERO);
    dhit = 1'b1; exDRE = 1'b1; exrt = 5'd5; idrs = 5'd5;
    step("dwait_lu_hit", C_LU);
    set_idle();
    step("run_again", C_ADV);

    // Halt beats a pending data wait; one drain cycle; then stopped.
    memHALT = 1'b1; memDRE = 1'b1;
    step("halt_enter", C_HALTC);
    set_idle();
    step("drain", C_DRAIN);
    for (int i = 0; i < 12; i++) begin
      ihit     = i[0];
      redirect = i[1];
      exDRE    = i[2];
      memHALT  = i[3];
      exrt     = 5'd7; idrs = 5'd7;
      step($sformatf("halted_%0d", i), C_HALTED);
    end

`ifdef PIPE_PERF_CNT_EN
    @(negedge CLK);
    check("cnt_stall", stall_cnt, 32'd4);
    check("cnt_flush", flush_cnt, 32'd3);
    check("cnt_dwait", dwait_cnt, 32'd6);
    @(posedge CLK); #1;
`endif

    // Reset from HALTED returns to RUN.
    set_idle();
    nRST = 1'b0;
    step("halted_reset", C_ZERO);
    set_idle();
    step("after_halt_reset", C_ADV);
`ifdef PIPE_PERF_CNT_EN
    check("cnt_cleared", stall_cnt | flush_cnt | dwait_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline. Drives the write-enable (xxW) and flush (xxRST) pair of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable.
- Resolves, in priority order: halt drain, data-memory wait, taken branch/jump redirect, load-use hazard, and instruction-memory wait.
- Sits beside the datapath. Only register inputs feed its combinational output paths; the only registered state is the FSM below.

Parameters:
- REGADDR_W, 5, register-file index width
- FLUSH_DEPTH, 3, number of younger registers flushed on redirect (IF/ID, ID/EX, EX/MEM); fixed at 3 for this pipeline

Ports:
- CLK  in  1  clock
- nRST  in  1  reset; synchronous, active-low; sampled on posedge CLK only
- ihit  in  1  instruction memory returned valid fetch this cycle
- dhit  in  1  data memory completed access this cycle
- memDRE  in  1  EX/MEM holds a load
- memDWE  in  1  EX/MEM holds a store
- exDRE  in  1  ID/EX holds a load
- exrt  in  REGADDR_W  load destination in ID/EX
- idrs, idrt  in  REGADDR_W  source registers of the instruction in IF/ID
- redirect  in  1  branch taken or jump/JR resolved in EX/MEM this cycle
- memHALT  in  1  EX/MEM holds HALT
- pcEN  out  1  PC loads next PC
- ifidW, ifidRST  out  1 each  IF/ID enable / bubble insert
- idexW, idexRST  out  1 each  ID/EX enable / bubble insert
- exmemW, exmemRST  out  1 each  EX/MEM enable / bubble insert
- memwbW, memwbRST  out  1 each  MEM/WB enable / bubble insert
- halted  out  1  processor stopped; sticky until reset

Behaviour:
- FSM states: RUN, DWAIT, DRAIN, HALTED. State is registered; outputs are combinational from state plus inputs. xxRST is meaningful only with xxW=1.
- Reset (nRST=0 at edge): state <= RUN. While nRST=0, outputs are pcEN=0, all W=0, all RST=0, halted=0.
- RUN, evaluated in priority order:
  1. memHALT: EX/MEM and MEM/WB advance; IF/ID, ID/EX, PC hold. Next state DRAIN.
  2. (memDRE|memDWE) & !dhit: all W=0, pcEN=0. Next state DWAIT.
  3. redirect: pcEN=1 even if ihit=0. ifidRST, idexRST, exmemRST =1 with W=1; memwbW=1. Stay in RUN.
  4. Load-use, i.e. exDRE & exrt!=0 & (exrt==idrs | exrt==idrt): pcEN=0, ifidW=0, idexW=1+idexRST=1, exmemW=memwbW=1.
  5. !ihit: pcEN=0, ifidW=1+ifidRST=1, rest advance.
  6. Otherwise: all W=1, no RST, pcEN=1.
  - A memory access with dhit=1 in the same cycle counts as complete: no DWAIT, fall through to rules 3-6.
- DWAIT: all W=0, pcEN=0 until dhit=1. In the dhit cycle, evaluate RUN rules 3-6 and go to RUN.
  - A redirect asserted during DWAIT is held stable by the frozen EX/MEM, so it is acted on in the dhit cycle.
- DRAIN: one cycle. MEM/WB writes with memwbW=1 so HALT retires. All other W=0, pcEN=0. Next state HALTED.
- HALTED: all W=0, pcEN=0, halted=1. Only reset exits.
- Reset asserted in any state returns to RUN on the next edge. A pending DWAIT is abandoned; the memory side must tolerate this.
- Register 0 never causes a load-use stall.
- Simultaneous load-use and !ihit: load-use wins; IF/ID holds with no bubble.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined: adds 32-bit outputs stall_cnt, flush_cnt, dwait_cnt, all reset to 0.
  - stall_cnt: +1 per load-use cycle.
  - flush_cnt: +1 per redirect cycle.
  - dwait_cnt: +1 per cycle spent in DWAIT.
  - All counters wrap at 2^32-1 to 0 and freeze in HALTED.
- Undefined: these ports and counters do not exist; the behaviour described above is otherwise identical.

Decomposition:
- cpu_types_pkg gains the FSM enum pctrl_state_t (RUN, DWAIT, DRAIN, HALTED) and the REGADDR_W constant.
- Sub-module hazard_detect: combinational load-use compare (exDRE, exrt, idrs, idrt -> lu_stall). It is reused by the forwarding work.

Test Plan:
- Reset: nRST=0 for 2 cycles -> pcEN=0, all W=0, halted=0. First cycle after release with ihit=1 -> all W=1, pcEN=1.
- Load-use: exDRE=1, exrt=8, idrs=8, ihit=1 -> exactly one cycle of pcEN=0, ifidW=0, idexRST=1. Repeat with exrt=0 -> no stall.
- Dmem wait: memDRE=1, dhit=0 for 3 cycles then 1 -> 3 cycles of all-W=0 (state DWAIT), full advance on the dhit cycle.
- Redirect during ihit=0: redirect=1, ihit=0 -> pcEN=1, ifidRST=idexRST=exmemRST=1, memwbW=1, no RST on MEM/WB.
- Halt: memHALT=1 -> DRAIN one cycle with only memwbW=1, then halted=1 held for 10+ cycles with all W=0. Reset mid-HALTED -> RUN.
- PIPE_PERF_CNT_EN: 2 load-use stalls, 1 redirect, 4 DWAIT cycles -> stall_cnt=2, flush_cnt=1, dwait_cnt=4.
